// File: rtl/fetch_sequencer.sv
// Instruction-pointer owner for instr_fetch: issues one fetch per cycle, tags returned words
// with their address and queues them for decode in a 2-entry valid/ready FIFO.
module fetch_sequencer #(
    parameter int unsigned WORD_SIZE              = 16,
    parameter int unsigned INS_ADDR_SIZE          = 16,
    parameter logic [INS_ADDR_SIZE-1:0] RESET_VECTOR = '0,
    parameter bit          START_RUNNING          = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [INS_ADDR_SIZE-1:0] pointer,
    output logic                     fetch_enable,
    input  logic [WORD_SIZE-1:0]     instr,
    output logic [WORD_SIZE-1:0]     instr_out,
    output logic [INS_ADDR_SIZE-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [INS_ADDR_SIZE-1:0] redirect_addr,
    output logic                     running
);

    typedef enum logic {
        HALTED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t state, state_next;

    logic [INS_ADDR_SIZE-1:0] pc;
    logic [INS_ADDR_SIZE-1:0] tag;
    logic                     inflight;
    logic                     drop;

    logic [WORD_SIZE-1:0]     fifo_word [2];
    logic [INS_ADDR_SIZE-1:0] fifo_pc   [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;

    logic       pop;
    logic       push;
    logic [2:0] pending;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    // The word returning this cycle is squashed both by a concurrent redirect and by drop.
    assign push        = inflight && !drop && !redirect_valid;
    assign pending     = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign pointer     = pc;
    assign running     = (state == RUN);
    assign instr_out   = instr_valid ? fifo_word[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= START_RUNNING ? RUN : HALTED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fetch_enable = 1'b0;
        if (halt) begin
            state_next = HALTED;
        end else if (start) begin
            state_next = RUN;
        end
        // Gated by reset_n so no request leaks out while reset is held.
        if (reset_n && state == RUN && !redirect_valid && pending < 3'd2) begin
            fetch_enable = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            tag      <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= fetch_enable;
            drop     <= redirect_valid && inflight;
            if (redirect_valid) begin
                pc <= redirect_addr;
            end else if (fetch_enable) begin
                pc  <= pc + 1'b1;
                tag <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= instr;
            fifo_pc[wr_ptr]   <= tag;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory returns 0x1000+addr one cycle after each fetch.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] pointer;
    logic        fetch_enable;
    logic [15:0] instr;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        running;

    int tests;
    int fails;

    logic        pend_fe;
    logic [15:0] pend_ptr;

    fetch_sequencer #(
        .WORD_SIZE    (16),
        .INS_ADDR_SIZE(16),
        .RESET_VECTOR (16'h0000),
        .START_RUNNING(1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pointer       (pointer),
        .fetch_enable  (fetch_enable),
        .instr         (instr),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .start         (start),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .running       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        start;
        logic        halt;
        logic        redir;
        logic [15:0] raddr;
        logic        fe;
        logic [15:0] ptr;
        logic        valid;
        logic [15:0] out;
        logic [15:0] ipc;
        logic        run;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic h, logic rv, logic [15:0] ra,
                                logic fe, logic [15:0] p, logic v, logic [15:0] o,
                                logic [15:0] ipc, logic run);
        vec_t t;
        t.ready = r;  t.start = s; t.halt = h; t.redir = rv; t.raddr = ra;
        t.fe    = fe; t.ptr = p;   t.valid = v; t.out = o;   t.ipc = ipc; t.run = run;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic s, logic h, logic rv, logic [15:0] ra);
        instr_ready    = r;
        start          = s;
        halt           = h;
        redirect_valid = rv;
        redirect_addr  = ra;
        #1;
    endtask

    task automatic expect_out(string tag, logic fe, logic [15:0] p, logic v,
                              logic [15:0] o, logic [15:0] ipc, logic run);
        chk({tag, ".fetch_enable"}, {31'b0, fetch_enable}, {31'b0, fe});
        chk({tag, ".pointer"},      {16'b0, pointer},      {16'b0, p});
        chk({tag, ".instr_valid"},  {31'b0, instr_valid},  {31'b0, v});
        chk({tag, ".instr_out"},    {16'b0, instr_out},    {16'b0, o});
        chk({tag, ".instr_pc"},     {16'b0, instr_pc},     {16'b0, ipc});
        chk({tag, ".running"},      {31'b0, running},      {31'b0, run});
    endtask

    // Memory responder: the word for the address fetched at the last edge appears this cycle.
    task automatic next_cycle();
        pend_fe  = fetch_enable;
        pend_ptr = pointer;
        @(negedge clk);
        instr = pend_fe ? 16'h1000 + pend_ptr : 16'hDEAD;
    endtask

    vec_t vecs[14];

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        instr   = 16'hDEAD;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Streaming, stall/resume, then a redirect with one word queued and one in flight.
        vecs[0]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        vecs[1]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 1);
        vecs[2]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1000, 16'h0000, 1);
        vecs[3]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h1001, 16'h0001, 1);
        vecs[4]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h1001, 16'h0001, 1);
        vecs[5]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h1001, 16'h0001, 1);
        vecs[6]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h1001, 16'h0001, 1);
        vecs[7]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0002, 1);
        vecs[8]  = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h1003, 16'h0003, 1);
        vecs[9]  = mk(1, 0, 0, 1, 16'h0040, 0, 16'h0006, 1, 16'h1004, 16'h0004, 1);
        vecs[10] = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 1);
        vecs[11] = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 16'h0000, 1);
        vecs[12] = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0042, 1, 16'h1040, 16'h0040, 1);
        vecs[13] = mk(1, 0, 0, 0, 16'h0000, 1, 16'h0043, 1, 16'h1041, 16'h0041, 1);

        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ready, vecs[i].start, vecs[i].halt, vecs[i].redir, vecs[i].raddr);
            expect_out($sformatf("vec%0d", i), vecs[i].fe, vecs[i].ptr, vecs[i].valid,
                       vecs[i].out, vecs[i].ipc, vecs[i].run);
            next_cycle();
        end

        // Address wrap at 0xFFFF.
        drive(1, 0, 0, 1, 16'hFFFF);
        expect_out("wrap0", 0, 16'h0044, 1, 16'h1042, 16'h0042, 1);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0000);
        expect_out("wrap1", 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        expect_out("wrap2", 1, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        expect_out("wrap3", 1, 16'h0001, 1, 16'h0FFF, 16'hFFFF, 1);
        next_cycle();
        expect_out("wrap4", 1, 16'h0002, 1, 16'h1000, 16'h0000, 1);
        next_cycle();

        // Halt with one queued and one in flight; both still delivered, then resume.
        drive(0, 0, 1, 0, 16'h0000);
        expect_out("halt0", 0, 16'h0003, 1, 16'h1001, 16'h0001, 1);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0000);
        expect_out("halt1", 0, 16'h0003, 1, 16'h1001, 16'h0001, 0);
        next_cycle();
        expect_out("halt2", 0, 16'h0003, 1, 16'h1002, 16'h0002, 0);
        next_cycle();
        drive(1, 1, 0, 0, 16'h0000);
        expect_out("start0", 0, 16'h0003, 0, 16'h0000, 16'h0000, 0);
        next_cycle();
        drive(1, 0, 0, 0, 16'h0000);
        expect_out("start1", 1, 16'h0003, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        expect_out("start2", 1, 16'h0004, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        expect_out("start3", 1, 16'h0005, 1, 16'h1003, 16'h0003, 1);
        next_cycle();

        // Asynchronous reset in the middle of streaming.
        reset_n = 1'b0;
        #1;
        expect_out("rst0", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        expect_out("rst1", 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        reset_n = 1'b1;
        #1;
        expect_out("rel0", 1, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        #1;
        expect_out("rel1", 1, 16'h0001, 0, 16'h0000, 16'h0000, 1);
        next_cycle();
        #1;
        expect_out("rel2", 1, 16'h0002, 1, 16'h1000, 16'h0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
